// File: rtl/bsg_arb_rr_idx.sv
// Round-robin arbiter: reduces up to els_p request lines to a registered winner index with a valid/yumi handshake.
// Optional grant counter (grant_cnt_o) is built only when BSG_ARB_RR_IDX_CNT_EN is defined.
module bsg_arb_rr_idx #(
   parameter int els_p    = 32,
   parameter int lg_els_p = $clog2(els_p)
) (
   input  logic                clk_i,
   input  logic                reset_n_i,
   input  logic [els_p-1:0]    reqs_i,
   output logic                v_o,
   output logic [lg_els_p-1:0] tag_o,
   input  logic                yumi_i
`ifdef BSG_ARB_RR_IDX_CNT_EN
   ,
   output logic [15:0]         grant_cnt_o
`endif
);

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [lg_els_p-1:0] tag_q, tag_d;
   logic [lg_els_p-1:0] last_q, last_d;

   logic [lg_els_p-1:0] search_ptr;
   logic [lg_els_p-1:0] scan_idx;
   logic [lg_els_p-1:0] winner;
   logic                any_req;
   logic                consume;

   assign consume = (state_q == OFFER) && yumi_i;
   assign any_req = |reqs_i;

   // Scan from ptr+1 upward with wrap; the downward loop lets the nearest hit
   // overwrite farther ones, and offset els_p lands back on ptr so it is checked last.
   always_comb begin
      search_ptr = consume ? tag_q : last_q;
      winner     = '0;
      scan_idx   = '0;
      for (int i = els_p; i >= 1; i--) begin
         scan_idx = search_ptr + lg_els_p'(i);
         if (reqs_i[scan_idx]) begin
            winner = scan_idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      tag_d   = tag_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               tag_d   = winner;
               state_d = OFFER;
            end
         end
         OFFER: begin
            // Requests are ignored until the offer is consumed, so the grant is sticky.
            if (yumi_i) begin
               last_d = tag_q;
               if (any_req) begin
                  tag_d = winner;
               end else begin
                  state_d = IDLE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         tag_q   <= '0;
         last_q  <= lg_els_p'(els_p - 1);
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
         last_q  <= last_d;
      end
   end

   assign v_o   = (state_q == OFFER);
   assign tag_o = tag_q;

`ifdef BSG_ARB_RR_IDX_CNT_EN
   logic [15:0] grant_cnt_q, grant_cnt_d;

   always_comb begin
      grant_cnt_d = grant_cnt_q;
      if (consume && (grant_cnt_q != 16'hFFFF)) begin
         grant_cnt_d = grant_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         grant_cnt_q <= '0;
      end else begin
         grant_cnt_q <= grant_cnt_d;
      end
   end

   assign grant_cnt_o = grant_cnt_q;
`endif

endmodule

// File: doc/bsg_arb_rr_idx.md
# bsg_arb_rr_idx

Round-robin arbiter that reduces up to 32 request lines to one registered winner index with a valid/yumi handshake. It sits directly upstream of the one-hot decode stage: `tag_o` drives the decoder's index input, and the decoder expands it into a one-hot grant vector. Arbitration fairness, hold-until-consumed semantics and pointer wrap-around all live here, so the decoder stays purely combinational.

## Interface
- `els_p`, default 32: number of request lines; power of two, 2..32.
- `lg_els_p`, default `$clog2(els_p)`: index width; derived, never overridden.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `reset_n_i`  in  1  reset; asynchronous, active-low.
- `reqs_i`  in  els_p  request vector; bit k high means requester k wants a grant.
- `v_o`  out  1  `tag_o` holds a valid winner.
- `tag_o`  out  lg_els_p  winner index; feeds the downstream decoder.
- `yumi_i`  in  1  consumer accepts the current winner; legal only while `v_o` is high.
- `grant_cnt_o`  out  16  grants issued; present only with `BSG_ARB_RR_IDX_CNT_EN`.

## Operation
- State: `v_r` (IDLE when 0, OFFER when 1), `tag_r`, `last_r` (index of the last consumed grant).
- Search: the winner is the first set bit of `reqs_i` scanning upward from `(last_r+1) mod els_p`, wrapping past `els_p-1` to 0. A bit equal to `last_r` is checked last.
- IDLE:
  - If `|reqs_i`, load `tag_r` with the winner and move to OFFER.
  - Otherwise stay in IDLE; `tag_r` is unchanged.
- OFFER:
  - `tag_o` and `v_o` hold stable until `yumi_i`.
  - Changes on `reqs_i` are ignored while offering, including the winning bit dropping. The grant is sticky.
- OFFER with `yumi_i`:
  - `last_r <= tag_r`.
  - The same cycle, run the search on the current `reqs_i`, with the pointer treated as the just-consumed `tag_r`.
  - Any request set: load the new winner and stay in OFFER, giving back-to-back grants.
  - No request set: go to IDLE.
- `yumi_i` while `v_o` is low: ignored, no state change. The bench flags it as a protocol error.
- Single requester held high: it wins every grant.
- Reset values:
  - `v_o=0`, `tag_o=0`, `last_r=els_p-1`, so the first search starts at index 0.
  - `grant_cnt_o=0`.
- Reset asserted mid-offer: all state returns to reset values immediately (asynchronous), and the pending grant is dropped. The first edge after deassertion behaves as IDLE.

## Timing
- Latency: request sampled on edge N gives `v_o` high after edge N. This is one cycle, from registered outputs.
- Throughput: one grant per cycle when `yumi_i` is held high and requests persist.
- All outputs come straight from flops. There is no combinational path from `reqs_i` or `yumi_i` to any output.
- The search is combinational over `els_p` bits, using doubled-vector or masked-priority logic. It must close at the target clock for `els_p=32`.
- `reset_n_i` assertion is asynchronous. Deassertion is assumed synchronized upstream.

## Configuration
- `BSG_ARB_RR_IDX_CNT_EN` defined:
  - `grant_cnt_o` exists and increments on every cycle with `v_o & yumi_i`.
  - It saturates at 16'hFFFF and resets to 0.
- Undefined: the port and the counter are absent, and arbitration behaviour is identical.

## Test plan
- Reset, then `reqs_i=32'h0000_0080` held: `v_o=1`, `tag_o=7` one cycle later. With `yumi_i` high, `tag_o` stays 7 on every following cycle.
- `reqs_i=32'hFFFF_FFFF`, `yumi_i=1` continuously: `tag_o` sequence 0,1,2,…,31,0,1 with `v_o` never dropping.
- Consume a grant of 30, then `reqs_i` bits 3 and 30 set: next `tag_o=3` (wrap). After consuming 3, next `tag_o=30`.
- Offer `tag_o=12` with `yumi_i=0` for 5 cycles while `reqs_i` drops to 0 on cycle 2: `tag_o=12` and `v_o=1` hold throughout. After `yumi_i`, `v_o=0` the next cycle.
- Assert `reset_n_i=0` mid-offer (`tag_o=9`): `v_o=0` and `tag_o=0` without waiting for a clock edge. After release with `reqs_i` bits 0 and 9 set, `tag_o=0`.
- With `BSG_ARB_RR_IDX_CNT_EN`: 70000 accepted grants leave `grant_cnt_o=16'hFFFF`. Cycles with `v_o` low or `yumi_i` low do not increment it.
